// File: rtl/riscv_pkg.sv
// RISC-V base opcodes and the shared 32-bit bus type.
package riscv_pkg;

    typedef logic [31:0] bus32_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;

endpackage

// File: rtl/tartaruga_pkg.sv
// Encoder-local types: instruction format enum, an encoded-word record and
// the opcode-to-format decode helper.
package tartaruga_pkg;
    import riscv_pkg::*;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U
    } enc_fmt_t;

    // One pipeline entry: the packed word and its range-error flag.
    typedef struct packed {
        bus32_t instr;
        logic   err;
    } enc_word_t;

    // Anything that is not a recognised U/I/S/B opcode is encoded as R-type.
    function automatic enc_fmt_t decode_fmt(input logic [6:0] opcode);
        enc_fmt_t fmt;
        case (opcode)
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_ALU_I, OP_LW:  fmt = FMT_I;
            OP_SW:            fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            default:          fmt = FMT_R;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction packer: format decode, field/immediate packing
// and (with INSTR_ENCODER_RANGE_CHECK_EN) immediate range checking.
module imm_pack
    import riscv_pkg::*;
    import tartaruga_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  bus32_t     imm,
    output bus32_t     instr,
    output logic       err
);

    enc_fmt_t fmt;
    bus32_t   word;

    // Pack fields and immediate bits for the decoded format.
    always_comb begin
        fmt  = decode_fmt(opcode);
        word = '0;
        case (fmt)
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
            default: word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic range_bad;

    // An immediate fits when every bit above the field's sign bit matches it.
    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            FMT_U:        range_bad = |imm[11:0];
            FMT_I, FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            default:      range_bad = 1'b0;
        endcase
    end

    assign instr = range_bad ? '0 : word;
    assign err   = range_bad;
`else
    assign instr = word;
    assign err   = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RISC-V instruction encoder with a one-entry output stage plus one skid
// entry, registered ready and a 16-bit accepted-request counter.
// Optional immediate range checking: define INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
    import tartaruga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  bus32_t      imm_i,
    input  logic        ready_i,
    output logic        ready_o,
    output logic        valid_o,
    output bus32_t      instr_o,
    output logic        err_o,
    output logic [15:0] cnt_o
);

    enc_word_t   new_word;
    enc_word_t   out_word_reg,  out_word_next;
    enc_word_t   skid_word_reg, skid_word_next;
    logic        out_valid_reg, out_valid_next;
    logic        skid_valid_reg, skid_valid_next;
    logic        ready_reg,     ready_next;
    logic [15:0] cnt_reg,       cnt_next;
    logic        accept;
    logic        consume;

    imm_pack u_imm_pack (
        .opcode (opcode_i),
        .rd     (rd_i),
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .funct3 (funct3_i),
        .funct7 (funct7_i),
        .imm    (imm_i),
        .instr  (new_word.instr),
        .err    (new_word.err)
    );

    // Next-state for output stage, skid entry, ready and counter.
    always_comb begin
        accept          = valid_i & ready_reg;
        consume         = out_valid_reg & ready_i;
        out_valid_next  = out_valid_reg;
        out_word_next   = out_word_reg;
        skid_valid_next = skid_valid_reg;
        skid_word_next  = skid_word_reg;
        if (skid_valid_reg) begin
            // ready is low here, so nothing new arrives; skid refills output.
            if (consume) begin
                out_word_next   = skid_word_reg;
                skid_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_reg || consume) begin
                out_valid_next = 1'b1;
                out_word_next  = new_word;
            end else begin
                skid_valid_next = 1'b1;
                skid_word_next  = new_word;
            end
        end else if (consume) begin
            out_valid_next = 1'b0;
        end
        ready_next = !skid_valid_next;
        cnt_next   = cnt_reg + {15'd0, accept};
    end

    // State registers; reset drops any buffered requests.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_valid_reg  <= 1'b0;
            out_word_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_word_reg  <= '0;
            ready_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_word_reg   <= out_word_next;
            skid_valid_reg <= skid_valid_next;
            skid_word_reg  <= skid_word_next;
            ready_reg      <= ready_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign ready_o = ready_reg;
    assign valid_o = out_valid_reg;
    assign instr_o = out_word_reg.instr;
    assign err_o   = out_word_reg.err;
    assign cnt_o   = cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps, randomized traffic
// and counter wrap, checked against a queue-based reference model.
module tb_instr_encoder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic [15:0] cnt_o;

    instr_encoder dut (
        .clk_i    (clk),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .opcode_i (opcode_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .ready_i  (ready_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .instr_o  (instr_o),
        .err_o    (err_o),
        .cnt_o    (cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of expected deliveries (capacity two) and a count.
    bit [31:0] q_instr[$];
    bit        q_err[$];
    int        m_cnt = 0;
    bit        m_ready = 1'b0;
    bit        last_acc = 1'b0;
    bit        verbose = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Encoding computed from the field-placement rules with shifts and masks.
    function automatic void ref_encode(input bit [6:0] op, input bit [4:0] rd,
                                       input bit [4:0] rs1, input bit [4:0] rs2,
                                       input bit [2:0] f3, input bit [6:0] f7,
                                       input bit [31:0] imm,
                                       output bit [31:0] w, output bit e);
        int v;
        bit [31:0] o, d, s1, s2, t3, t7;
        v  = int'(imm);
        o  = 32'(op);
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        t3 = 32'(f3) << 12;
        t7 = 32'(f7) << 25;
        if (op == OP_LUI || op == OP_AUIPC) begin
            w = (imm & 32'hFFFF_F000) | d | o;
            e = (imm & 32'h0000_0FFF) != 0;
        end else if (op == OP_ALU_I || op == OP_LW) begin
            w = ((imm & 32'hFFF) << 20) | s1 | t3 | d | o;
            e = (v < -2048) || (v > 2047);
        end else if (op == OP_SW) begin
            w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | t3 | ((imm & 32'h1F) << 7) | o;
            e = (v < -2048) || (v > 2047);
        end else if (op == OP_BRANCH) begin
            w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | t3 |
                (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            e = (v < -4096) || (v > 4094) || (v % 2 != 0);
        end else begin
            w = t7 | s2 | s1 | t3 | d | o;
            e = 1'b0;
        end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (e) w = 32'h0;
`else
        e = 1'b0;
`endif
    endfunction

    task automatic set_req(input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                           input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
                           input bit [31:0] imm);
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    // One clock: update the model at the edge, check every output at negedge.
    task automatic cycle();
        bit [31:0] w;
        bit        e;
        bit        con;
        @(posedge clk);
        last_acc = 1'b0;
        if (!rstn_i) begin
            q_instr.delete();
            q_err.delete();
            m_cnt   = 0;
            m_ready = 1'b0;
        end else begin
            last_acc = valid_i && m_ready;
            con      = (q_instr.size() > 0) && ready_i;
            if (con) begin
                if (verbose) $display("txn deliver instr=%h err=%0b", q_instr[0], q_err[0]);
                void'(q_instr.pop_front());
                void'(q_err.pop_front());
            end
            if (last_acc) begin
                ref_encode(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, w, e);
                q_instr.push_back(w);
                q_err.push_back(e);
                m_cnt = (m_cnt + 1) % 65536;
                if (verbose) $display("txn accept op=%b imm=%h cnt=%0d", opcode_i, imm_i, m_cnt);
            end
            m_ready = q_instr.size() < 2;
        end
        @(negedge clk);
        check("valid_o", 32'(valid_o), 32'(q_instr.size() > 0));
        check("ready_o", 32'(ready_o), 32'(m_ready));
        check("cnt_o", 32'(cnt_o), 32'(m_cnt));
        if (q_instr.size() > 0) begin
            check("instr_o", instr_o, q_instr[0]);
            check("err_o", 32'(err_o), 32'(q_err[0]));
        end
    endtask

    int base_cnt;
    int budget;
    bit hold;
    bit [6:0] ops[9];
    bit [31:0] imms[12];

    initial begin
        ops  = '{OP_LUI, OP_AUIPC, OP_ALU_I, OP_LW, OP_SW, OP_BRANCH, OP_ALU_R, OP_JAL, OP_JALR};
        imms = '{32'hFFFF_F800, 32'd2047, 32'd2048, 32'hFFFF_F7FF, 32'hFFFF_F000, 32'd4094,
                 32'd4095, 32'd4096, 32'hFFFF_EFFE, 32'h1234_5000, 32'd0, 32'd3};

        // Reset state.
        @(negedge clk);
        cycle();
        cycle();
        check("rst_instr", instr_o, 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        rstn_i = 1'b1;
        cycle();
        check("ready_after_rst", 32'(ready_o), 32'h1);

        // Directed encodings, back to back with the consumer ready.
        valid_i = 1'b1;
        set_req(OP_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        check("addi_word", instr_o, 32'h0050_0093);
        check("addi_err", 32'(err_o), 32'h0);
        check("addi_cnt", 32'(cnt_o), 32'h1);
        set_req(OP_SW, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        cycle();
        check("sw_word", instr_o, 32'h0020_A423);
        set_req(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle();
        check("lui_word", instr_o, 32'h1234_52B7);
        set_req(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        cycle();
        check("beq_word", instr_o, 32'hFE00_0EE3);
        set_req(OP_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        cycle();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        check("addi_big_err", 32'(err_o), 32'h1);
        check("addi_big_word", instr_o, 32'h0);
`else
        check("addi_big_err", 32'(err_o), 32'h0);
        check("addi_big_word", instr_o, 32'h0000_0093);
`endif
        set_req(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        cycle();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        check("beq_odd_err", 32'(err_o), 32'h1);
        check("beq_odd_word", instr_o, 32'h0);
`else
        check("beq_odd_err", 32'(err_o), 32'h0);
        check("beq_odd_word", instr_o, 32'h0000_0163);
`endif
        valid_i = 1'b0;
        cycle();
        cycle();

        // Backpressure: two accepted, third held until space frees up.
        base_cnt = m_cnt;
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        set_req(OP_ALU_I, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'd17);
        cycle();
        set_req(OP_SW, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, 32'hFFFF_FFF0);
        cycle();
        check("bp_ready_low", 32'(ready_o), 32'h0);
        set_req(OP_ALU_R, 5'd8, 5'd9, 5'd10, 3'd0, 7'h20, 32'd0);
        cycle();
        cycle();
        check("bp_third_held", 32'(cnt_o), 32'((base_cnt + 2) % 65536));
        ready_i = 1'b1;
        budget  = 0;
        do begin
            cycle();
            budget++;
        end while (!last_acc && budget < 8);
        if (!last_acc) check("bp_accept_timeout", 32'h0, 32'h1);
        valid_i = 1'b0;
        repeat (3) cycle();
        check("bp_cnt", 32'(cnt_o), 32'((base_cnt + 3) % 65536));

        // Reset with output and skid both occupied.
        ready_i = 1'b0;
        valid_i = 1'b1;
        set_req(OP_LW, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'd12);
        cycle();
        set_req(OP_LW, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd16);
        cycle();
        valid_i = 1'b0;
        rstn_i  = 1'b0;
        cycle();
        check("midrst_valid", 32'(valid_o), 32'h0);
        check("midrst_cnt", 32'(cnt_o), 32'h0);
        check("midrst_ready", 32'(ready_o), 32'h0);
        rstn_i  = 1'b1;
        ready_i = 1'b1;
        cycle();
        check("postrst_ready", 32'(ready_o), 32'h1);
        cycle();
        check("postrst_no_stale", 32'(valid_o), 32'h0);

        // Randomized traffic; an unaccepted request is held unchanged.
        verbose = 1'b0;
        hold    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                valid_i = ($urandom_range(0, 3) != 0);
                set_req(ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom),
                        3'($urandom), 7'($urandom),
                        ($urandom_range(0, 2) == 0) ? $urandom : imms[$urandom_range(0, 11)]);
            end
            ready_i = ($urandom_range(0, 2) != 0);
            cycle();
            hold = valid_i && !last_acc;
        end
        $display("txn random phase done cnt=%0d", m_cnt);

        // Counter wrap: accept every cycle until the count rolls over.
        valid_i = 1'b1;
        ready_i = 1'b1;
        set_req(OP_ALU_I, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        budget = 0;
        while (m_cnt != 65535 && budget < 70000) begin
            cycle();
            budget++;
        end
        if (m_cnt != 65535) check("wrap_timeout", 32'(m_cnt), 32'd65535);
        check("cnt_max", 32'(cnt_o), 32'hFFFF);
        cycle();
        check("cnt_wrap", 32'(cnt_o), 32'h0);
        $display("txn counter wrap reached cnt=%0d", cnt_o);
        valid_i = 1'b0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
